dither_gen: RTL and testbench

Parametrised multi-channel LFSR dither generator for the delta-sigma modulator input path. N_LFSR independent 32-bit maximal-length LFSRs are summed into a signed dither word with selectable amplitude distribution (off / rectangular / triangular / multi-source) and a programmable amplitude shift. Seeds are loadable at runtime through a valid/ready port, and LFSR lock-up states are prevented. The output is registered, strobed, and consumed by the modulator's quantiser adder.

---
 rtl/dither_gen.sv | 114 +++++++++++
 tb/tb_dither_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_gen.sv
// Multi-channel LFSR dither generator: N_LFSR 32-bit Fibonacci LFSRs summed into a
// signed, shifted and saturated dither word for the delta-sigma quantiser adder.
module dither_gen #(
  parameter int          N_LFSR   = 4,
  parameter int          TAP_BITS = 9,
  parameter int          OUT_W    = 11,
  parameter logic [31:0] SEED     = 32'hACE1_2345
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [2:0]              amp_shift,
  input  logic                    seed_valid,
  input  logic [31:0]             seed_data,
  output logic                    seed_ready,
  output logic signed [OUT_W-1:0] dith_o,
  output logic                    dith_valid
);

  localparam int SUM_W = TAP_BITS + 3;
  localparam int EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam int PTR_W = (N_LFSR > 1) ? $clog2(N_LFSR) : 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (OUT_W - 1)));

  // Reset seeds are spread by the golden-ratio constant; all-ones is the lock-up state.
  function automatic logic [31:0] reset_seed(input int idx);
    logic [31:0] s;
    s = SEED + 32'(idx) * 32'h9E37_79B9;
    return (s == 32'hFFFF_FFFF) ? 32'h0000_0001 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ~^ s[21] ~^ s[1] ~^ s[0]};
  endfunction

  function automatic logic signed [SUM_W-1:0] slice(input logic [31:0] s);
    return {{3{s[TAP_BITS-1]}}, s[TAP_BITS-1:0]};
  endfunction

  logic [31:0]              r_lfsr [N_LFSR];
  logic [PTR_W-1:0]         r_ptr;
  logic signed [OUT_W-1:0]  r_dith;
  logic                     r_valid;

  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic signed [EXT_W-1:0]  w_y_ext;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     w_load;

  // Seed port: a word transfers on a rising edge where seed_valid && seed_ready;
  // seed_ready is simply !en, so seeds can only be written while the generator is idle.
  assign seed_ready = !en;
  assign w_load     = seed_valid && seed_ready;

  always_comb begin
    w_sum = '0;
    case (mode)
      2'd1: w_sum = slice(r_lfsr[0]);
      2'd2: w_sum = slice(r_lfsr[0]) + slice(r_lfsr[1]);
      2'd3: begin
        for (int i = 0; i < N_LFSR; i++) begin
          w_sum = w_sum + slice(r_lfsr[i]);
        end
      end
      default: w_sum = '0;
    endcase
  end

  assign w_shift = w_sum >>> amp_shift;
  assign w_y_ext = {{(EXT_W - SUM_W){w_shift[SUM_W-1]}}, w_shift};

  always_comb begin
    w_sat = w_y_ext[OUT_W-1:0];
    if (w_y_ext > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_y_ext < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LFSR; i++) begin
        r_lfsr[i] <= reset_seed(i);
      end
      r_ptr   <= '0;
      r_dith  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_dith <= w_sat;
        for (int i = 0; i < N_LFSR; i++) begin
          r_lfsr[i] <= lfsr_next(r_lfsr[i]);
        end
      end else if (w_load) begin
        // An all-ones seed would lock the channel, so it falls back to the reset seed.
        for (int i = 0; i < N_LFSR; i++) begin
          if (r_ptr == PTR_W'(i)) begin
            r_lfsr[i] <= (seed_data == 32'hFFFF_FFFF) ? reset_seed(i) : seed_data;
          end
        end
        r_ptr <= (r_ptr == PTR_W'(N_LFSR - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
    end
  end

  assign dith_o     = r_dith;
  assign dith_valid = r_valid;

endmodule

// File: tb/tb_dither_gen.sv
// Directed bench for dither_gen: default instance (TAP_BITS=9) against an LFSR model,
// plus a TAP_BITS=16 instance for saturation and shift boundaries.
module tb_dither_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  logic               en, seed_valid, seed_ready, dith_valid;
  logic [1:0]         mode;
  logic [2:0]         amp_shift;
  logic [31:0]        seed_data;
  logic signed [10:0] dith_o;

  logic               en_w, seed_valid_w, seed_ready_w, dith_valid_w;
  logic [1:0]         mode_w;
  logic [2:0]         amp_w;
  logic [31:0]        seed_data_w;
  logic signed [10:0] dith_w;

  dither_gen dut (
    .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .amp_shift(amp_shift),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .dith_o(dith_o), .dith_valid(dith_valid)
  );

  dither_gen #(.N_LFSR(4), .TAP_BITS(16), .OUT_W(11)) dut_w (
    .clock(clock), .reset_n(reset_n), .en(en_w), .mode(mode_w), .amp_shift(amp_w),
    .seed_valid(seed_valid_w), .seed_data(seed_data_w), .seed_ready(seed_ready_w),
    .dith_o(dith_w), .dith_valid(dith_valid_w)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_s [4];
  int          m_ptr;
  logic [10:0] exp_q [$];

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return {s[30:0], s[31] ~^ s[21] ~^ s[1] ~^ s[0]};
  endfunction

  function automatic logic [31:0] m_reset_seed(input int i);
    logic [31:0] s;
    s = 32'hACE1_2345 + 32'(i) * 32'h9E37_79B9;
    return (s == 32'hFFFF_FFFF) ? 32'h1 : s;
  endfunction

  function automatic int m_slice(input logic [31:0] s);
    int v;
    v = int'(s[8:0]);
    if (v >= 256) v = v - 512;
    return v;
  endfunction

  function automatic int m_expect(input int md, input int sh);
    int sum;
    sum = 0;
    if (md == 1) sum = m_slice(m_s[0]);
    if (md == 2) sum = m_slice(m_s[0]) + m_slice(m_s[1]);
    if (md == 3) sum = m_slice(m_s[0]) + m_slice(m_s[1]) + m_slice(m_s[2]) + m_slice(m_s[3]);
    sum = sum >>> sh;
    if (sum > 1023) sum = 1023;
    if (sum < -1024) sum = -1024;
    return sum;
  endfunction

  task automatic m_advance();
    for (int i = 0; i < 4; i++) m_s[i] = m_step(m_s[i]);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_s[i] = m_reset_seed(i);
    m_ptr = 0;
  endtask

  task automatic m_load(input logic [31:0] d);
    m_s[m_ptr] = (d == 32'hFFFF_FFFF) ? m_reset_seed(m_ptr) : d;
    m_ptr = (m_ptr == 3) ? 0 : m_ptr + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 0; seed_valid = 0; mode = 0; amp_shift = 0; seed_data = 0;
    en_w = 0; seed_valid_w = 0; mode_w = 0; amp_w = 0; seed_data_w = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    checks++;
    if (dith_o !== 11'sd0 || dith_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got dith=%0d valid=%b exp dith=0 valid=0", dith_o, dith_valid);
    end
    checks++;
    if (seed_ready !== 1'b1 || seed_ready_w !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b/%b exp 1/1", seed_ready, seed_ready_w);
    end
    checks++;
    if (dith_w !== 11'sd0 || dith_valid_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_w got dith=%0d valid=%b exp 0/0", dith_w, dith_valid_w);
    end
    @(posedge clock); #1;
    checks++;
    if (dith_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid got %b exp 0", dith_valid);
    end
  endtask

  task automatic test_rect();
    int e;
    mode = 2'd1; amp_shift = 3'd0; en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dith_valid !== 1'b1 || dith_o !== -11'sd187) begin
      failures++;
      $display("FAIL rect_first got dith=%0d valid=%b exp -187/1", dith_o, dith_valid);
    end
    m_advance();
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'sd138) begin
      failures++;
      $display("FAIL rect_second got %0d exp 138", dith_o);
    end
    m_advance();
    e = m_expect(1, 0);
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'(e)) begin
      failures++;
      $display("FAIL rect_third got %0d exp %0d", dith_o, e);
    end
    m_advance();
    en = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (dith_valid !== 1'b0 || dith_o !== 11'(e)) begin
      failures++;
      $display("FAIL rect_hold got dith=%0d valid=%b exp %0d/0", dith_o, dith_valid, e);
    end
  endtask

  task automatic test_mode0();
    int e;
    mode = 2'd0; en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      checks++;
      if (dith_o !== 11'sd0 || dith_valid !== 1'b1) begin
        failures++;
        $display("FAIL mode0_zero cycle=%0d got dith=%0d valid=%b exp 0/1", c, dith_o, dith_valid);
      end
      m_advance();
    end
    mode = 2'd1;
    e = m_expect(1, 0);
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'(e)) begin
      failures++;
      $display("FAIL mode0_then_rect got %0d exp %0d", dith_o, e);
    end
    m_advance();
    en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_seed_load();
    logic [31:0] seeds [4];
    int e;
    seeds[0] = 32'h1; seeds[1] = 32'h2; seeds[2] = 32'hFFFF_FFFF; seeds[3] = 32'h4;
    for (int k = 0; k < 4; k++) begin
      seed_data = seeds[k]; seed_valid = 1'b1;
      checks++;
      if (seed_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_ready k=%0d got %b exp 1", k, seed_ready);
      end
      @(posedge clock); #1;
      m_load(seeds[k]);
    end
    seed_valid = 1'b0;
    mode = 2'd3; amp_shift = 3'd0; en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'sd190) begin
      failures++;
      $display("FAIL load_sum got %0d exp 190", dith_o);
    end
    m_advance();
    // Offer a seed while running: port must be busy and nothing may load.
    seed_valid = 1'b1; seed_data = 32'h1234_5678;
    checks++;
    if (seed_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_busy got %b exp 0", seed_ready);
    end
    e = m_expect(3, 0);
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'(e)) begin
      failures++;
      $display("FAIL load_ignored got %0d exp %0d", dith_o, e);
    end
    m_advance();
    en = 1'b0;
    // Fifth load wraps the pointer back to channel 0.
    seed_data = 32'h0000_00FF;
    @(posedge clock); #1;
    m_load(32'h0000_00FF);
    seed_valid = 1'b0;
    mode = 2'd1; en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'sd255) begin
      failures++;
      $display("FAIL load_wrap got %0d exp 255", dith_o);
    end
    m_advance();
    en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_amp_shift();
    int e;
    mode = 2'd3; en = 1'b1;
    for (int sh = 0; sh < 8; sh++) begin
      amp_shift = 3'(sh);
      e = m_expect(3, sh);
      @(posedge clock); #1;
      checks++;
      if (dith_o !== 11'(e)) begin
        failures++;
        $display("FAIL amp_shift sh=%0d got %0d exp %0d", sh, dith_o, e);
      end
      m_advance();
    end
    en = 1'b0; amp_shift = 3'd0;
    @(posedge clock); #1;
  endtask

  task automatic test_saturation();
    logic [31:0] sv [10];
    int          sh [10];
    int          ev [10];
    sv[0] = 32'h7FFF; sh[0] = 0; ev[0] = 1023;
    sv[1] = 32'h7FFF; sh[1] = 7; ev[1] = 1023;
    sv[2] = 32'h8000; sh[2] = 0; ev[2] = -1024;
    sv[3] = 32'h8000; sh[3] = 7; ev[3] = -1024;
    sv[4] = 32'hFFFF; sh[4] = 1; ev[4] = -2;
    sv[5] = 32'hFFFF; sh[5] = 3; ev[5] = -1;
    sv[6] = 32'h0005; sh[6] = 2; ev[6] = 5;
    sv[7] = 32'h0100; sh[7] = 0; ev[7] = 1023;
    sv[8] = 32'h0100; sh[8] = 1; ev[8] = 512;
    sv[9] = 32'hFEFF; sh[9] = 0; ev[9] = -1024;
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 4; k++) begin
        seed_data_w = sv[t]; seed_valid_w = 1'b1;
        @(posedge clock); #1;
      end
      seed_valid_w = 1'b0;
      mode_w = 2'd3; amp_w = 3'(sh[t]); en_w = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (dith_w !== 11'(ev[t]) || dith_valid_w !== 1'b1) begin
        failures++;
        $display("FAIL sat case=%0d got %0d/%b exp %0d/1", t, dith_w, dith_valid_w, ev[t]);
      end
      en_w = 1'b0;
    end
  endtask

  task automatic test_long_run();
    logic [10:0] e;
    int mn, mx;
    mn = 0; mx = 0;
    mode = 2'd2; amp_shift = 3'd0; en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      exp_q.push_back(11'(m_expect(2, 0)));
      @(posedge clock); #1;
      m_advance();
      e = exp_q.pop_front();
      checks++;
      if (dith_o !== e || dith_valid !== 1'b1) begin
        failures++;
        $display("FAIL long_run cycle=%0d got %0d/%b exp %0d/1", c, dith_o, dith_valid, $signed(e));
      end
      if (int'(dith_o) < mn) mn = int'(dith_o);
      if (int'(dith_o) > mx) mx = int'(dith_o);
    end
    en = 1'b0;
    checks++;
    if (mn < -512 || mx > 510) begin
      failures++;
      $display("FAIL long_range got min=%0d max=%0d exp within -512..510", mn, mx);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_stream();
    int e;
    mode = 2'd1; amp_shift = 3'd0; en = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      m_advance();
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dith_o !== 11'sd0 || dith_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_clear got dith=%0d valid=%b exp 0/0", dith_o, dith_valid);
    end
    en = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    m_reset();
    en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dith_o !== -11'sd187 || dith_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart_first got %0d/%b exp -187/1", dith_o, dith_valid);
    end
    m_advance();
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'sd138) begin
      failures++;
      $display("FAIL restart_second got %0d exp 138", dith_o);
    end
    m_advance();
    en = 1'b0;
    // Pointer must be back at channel 0 after reset.
    seed_data = 32'h0000_0003; seed_valid = 1'b1;
    @(posedge clock); #1;
    m_load(32'h3);
    seed_valid = 1'b0; en = 1'b1;
    e = m_expect(1, 0);
    @(posedge clock); #1;
    checks++;
    if (dith_o !== 11'sd3 || e != 3) begin
      failures++;
      $display("FAIL restart_ptr got %0d exp 3", dith_o);
    end
    en = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_rect();
    test_mode0();
    test_seed_load();
    test_amp_shift();
    test_saturation();
    test_long_run();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
